// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder-buffer controller.
// Every ROB file imports this package so the entry layout is defined once.
package rob_pkg;

    localparam int DEPTH          = 8;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int TAG_WIDTH      = $clog2(DEPTH);

    // Occupancy value that means "every slot holds an instruction".
    localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        logic                      valid;
        logic                      complete;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]     value;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// Circular ROB entry storage: allocate, CDB update and retire write ports,
// a synchronous clear, and an asynchronous read of the head entry.
module rob_entry_array
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      alloc_en,
    input  logic [TAG_WIDTH-1:0]      alloc_idx,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_dest,
    input  logic                      update_en,
    input  logic [TAG_WIDTH-1:0]      update_idx,
    input  logic [DATA_WIDTH-1:0]     update_value,
    input  logic                      retire_en,
    input  logic [TAG_WIDTH-1:0]      retire_idx,
    input  logic [TAG_WIDTH-1:0]      head_idx,
    output rob_entry_t                head_entry
);

    rob_entry_t entries [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: only the control bits are cleared; dest/value are never
            // observed without valid, so the payload RAM needs no reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].complete <= 1'b0;
            end
        end else begin
            // Later writes win: retire beats a stray CDB hit on the head, and
            // allocation beats a CDB hit on the slot being allocated.
            if (update_en && entries[update_idx].valid) begin
                entries[update_idx].complete <= 1'b1;
                entries[update_idx].value    <= update_value;
            end
            if (retire_en) begin
                entries[retire_idx].valid    <= 1'b0;
                entries[retire_idx].complete <= 1'b0;
            end
            if (alloc_en) begin
                entries[alloc_idx].valid    <= 1'b1;
                entries[alloc_idx].complete <= 1'b0;
                entries[alloc_idx].dest     <= alloc_dest;
            end
        end
    end

    assign head_entry = entries[head_idx];

endmodule

// File: rtl/rob_ctrl.sv
// In-order reorder-buffer controller: tag allocation, CDB completion,
// in-order retirement and mispredict flush over a circular entry array.
module rob_ctrl
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dispatch_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dispatch_dest,
    output logic                      dispatch_ready,
    output logic [TAG_WIDTH-1:0]      dispatch_tag,
    input  logic                      cdb_valid,
    input  logic [TAG_WIDTH-1:0]      cdb_tag,
    input  logic [DATA_WIDTH-1:0]     cdb_value,
    output logic                      commit_valid,
    output logic [REG_ADDR_WIDTH-1:0] commit_dest,
    output logic [DATA_WIDTH-1:0]     commit_value,
    output logic [TAG_WIDTH-1:0]      commit_tag,
    input  logic                      commit_ready,
    input  logic                      flush,
    output logic                      full,
    output logic                      empty,
    output logic [TAG_WIDTH:0]        count
);

    logic [TAG_WIDTH-1:0] head;
    logic [TAG_WIDTH-1:0] tail;
    logic [TAG_WIDTH:0]   count_q;
    logic [TAG_WIDTH:0]   count_next;
    logic                 accept;
    logic                 retire;
    logic                 clear;
    rob_entry_t           head_entry;

    // Reset and flush share one clear path; both discard every entry.
    assign clear  = !rst_n || flush;
    assign accept = dispatch_valid && !full;
    assign retire = commit_valid && commit_ready;

    rob_entry_array u_entries (
        .clk          (clk),
        .clear        (clear),
        .alloc_en     (accept),
        .alloc_idx    (tail),
        .alloc_dest   (dispatch_dest),
        .update_en    (cdb_valid),
        .update_idx   (cdb_tag),
        .update_value (cdb_value),
        .retire_en    (retire),
        .retire_idx   (head),
        .head_idx     (head),
        .head_entry   (head_entry)
    );

    always_comb begin
        count_next = count_q;
        if (accept && !retire) begin
            count_next = count_q + (TAG_WIDTH + 1)'(1);
        end else if (!accept && retire) begin
            count_next = count_q - (TAG_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                tail <= tail + TAG_WIDTH'(1);
            end
            if (retire) begin
                head <= head + TAG_WIDTH'(1);
            end
            count_q <= count_next;
        end
    end

    assign count          = count_q;
    assign full           = (count_q == FULL_COUNT);
    assign empty          = (count_q == '0);
    assign dispatch_ready = !full;
    assign dispatch_tag   = tail;
    assign commit_valid   = head_entry.valid && head_entry.complete;
    assign commit_dest    = head_entry.dest;
    assign commit_value   = head_entry.value;
    assign commit_tag     = head;

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: a directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_rob_ctrl;
    import rob_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      dispatch_valid;
    logic [REG_ADDR_WIDTH-1:0] dispatch_dest;
    logic                      dispatch_ready;
    logic [TAG_WIDTH-1:0]      dispatch_tag;
    logic                      cdb_valid;
    logic [TAG_WIDTH-1:0]      cdb_tag;
    logic [DATA_WIDTH-1:0]     cdb_value;
    logic                      commit_valid;
    logic [REG_ADDR_WIDTH-1:0] commit_dest;
    logic [DATA_WIDTH-1:0]     commit_value;
    logic [TAG_WIDTH-1:0]      commit_tag;
    logic                      commit_ready;
    logic                      flush;
    logic                      full;
    logic                      empty;
    logic [TAG_WIDTH:0]        count;

    int passed = 0;
    int total  = 0;

    rob_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dispatch_valid (dispatch_valid),
        .dispatch_dest  (dispatch_dest),
        .dispatch_ready (dispatch_ready),
        .dispatch_tag   (dispatch_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .commit_valid   (commit_valid),
        .commit_dest    (commit_dest),
        .commit_value   (commit_value),
        .commit_tag     (commit_tag),
        .commit_ready   (commit_ready),
        .flush          (flush),
        .full           (full),
        .empty          (empty),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [REG_ADDR_WIDTH-1:0] dd,
                         input logic cv, input logic [TAG_WIDTH-1:0] ct,
                         input logic [DATA_WIDTH-1:0] cval, input logic cr, input logic fl);
        dispatch_valid = dv;
        dispatch_dest  = dd;
        cdb_valid      = cv;
        cdb_tag        = ct;
        cdb_value      = cval;
        commit_ready   = cr;
        flush          = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_state(input string name, input int cnt, input int dtag,
                                input logic cvalid, input int ctag);
        check({name, ".count"}, 64'(count), 64'(cnt));
        check({name, ".full"}, 64'(full), 64'(cnt == DEPTH));
        check({name, ".empty"}, 64'(empty), 64'(cnt == 0));
        check({name, ".dispatch_ready"}, 64'(dispatch_ready), 64'(cnt != DEPTH));
        check({name, ".dispatch_tag"}, 64'(dispatch_tag), 64'(dtag));
        check({name, ".commit_valid"}, 64'(commit_valid), 64'(cvalid));
        check({name, ".commit_tag"}, 64'(commit_tag), 64'(ctag));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                      dv;
        logic [REG_ADDR_WIDTH-1:0] dd;
        logic                      cv;
        logic [TAG_WIDTH-1:0]      ct;
        logic [DATA_WIDTH-1:0]     cval;
        logic                      cr;
        int                        e_count;
        int                        e_dtag;
        logic                      e_cvalid;
        logic [REG_ADDR_WIDTH-1:0] e_cdest;
        logic [DATA_WIDTH-1:0]     e_cvalue;
        int                        e_ctag;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic dv, input logic [REG_ADDR_WIDTH-1:0] dd,
                                input logic cv, input logic [TAG_WIDTH-1:0] ct,
                                input logic [DATA_WIDTH-1:0] cval, input logic cr,
                                input int cnt, input int dtag, input logic cvalid,
                                input logic [REG_ADDR_WIDTH-1:0] cdest,
                                input logic [DATA_WIDTH-1:0] cvalue, input int ctag);
        vec_t v;
        v.dv = dv; v.dd = dd; v.cv = cv; v.ct = ct; v.cval = cval; v.cr = cr;
        v.e_count = cnt; v.e_dtag = dtag; v.e_cvalid = cvalid;
        v.e_cdest = cdest; v.e_cvalue = cvalue; v.e_ctag = ctag;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int                        tag;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      done;
        logic [DATA_WIDTH-1:0]     value;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_head = 0;
    int       m_tail = 0;

    // Advance the model by one clock using the inputs currently being driven.
    task automatic model_step();
        logic ret;
        logic acc;
        m_entry_t e;
        if (!rst_n || flush) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            return;
        end
        ret = (mq.size() > 0) && mq[0].done && commit_ready;
        acc = dispatch_valid && (mq.size() < DEPTH);
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(cdb_tag)) begin
                    mq[i].done  = 1'b1;
                    mq[i].value = cdb_value;
                end
            end
        end
        if (ret) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (acc) begin
            e.tag = m_tail; e.dest = dispatch_dest; e.done = 1'b0; e.value = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic compare_model(input int cyc);
        logic exp_cvalid;
        exp_cvalid = (mq.size() > 0) && mq[0].done;
        expect_state($sformatf("rand%0d", cyc), mq.size(), m_tail, exp_cvalid, m_head);
        if (exp_cvalid) begin
            check("rand.commit_dest", 64'(commit_dest), 64'(mq[0].dest));
            check("rand.commit_value", 64'(commit_value), 64'(mq[0].value));
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        do_reset();
        expect_state("reset", 0, 0, 1'b0, 0);

        // Dispatch 3,4,5; out-of-order completion; in-order commit.
        vecs[0]  = mk(1'b1, 5'd3, 1'b0, 3'd0, 32'h0,   1'b0, 1, 1, 1'b0, 5'd0, 32'h0,  0);
        vecs[1]  = mk(1'b1, 5'd4, 1'b0, 3'd0, 32'h0,   1'b0, 2, 2, 1'b0, 5'd0, 32'h0,  0);
        vecs[2]  = mk(1'b1, 5'd5, 1'b0, 3'd0, 32'h0,   1'b0, 3, 3, 1'b0, 5'd0, 32'h0,  0);
        vecs[3]  = mk(1'b0, 5'd0, 1'b1, 3'd1, 32'hAA,  1'b1, 3, 3, 1'b0, 5'd0, 32'h0,  0);
        vecs[4]  = mk(1'b0, 5'd0, 1'b1, 3'd0, 32'h55,  1'b1, 3, 3, 1'b1, 5'd3, 32'h55, 0);
        vecs[5]  = mk(1'b0, 5'd0, 1'b0, 3'd0, 32'h0,   1'b1, 2, 3, 1'b1, 5'd4, 32'hAA, 1);
        vecs[6]  = mk(1'b0, 5'd0, 1'b0, 3'd0, 32'h0,   1'b1, 1, 3, 1'b0, 5'd0, 32'h0,  2);
        vecs[7]  = mk(1'b0, 5'd0, 1'b0, 3'd0, 32'h0,   1'b1, 1, 3, 1'b0, 5'd0, 32'h0,  2);
        vecs[8]  = mk(1'b0, 5'd0, 1'b1, 3'd2, 32'h77,  1'b0, 1, 3, 1'b1, 5'd5, 32'h77, 2);
        vecs[9]  = mk(1'b0, 5'd0, 1'b0, 3'd0, 32'h0,   1'b1, 0, 3, 1'b0, 5'd0, 32'h0,  3);
        vecs[10] = mk(1'b0, 5'd0, 1'b1, 3'd6, 32'h123, 1'b1, 0, 3, 1'b0, 5'd0, 32'h0,  3);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].dv, vecs[i].dd, vecs[i].cv, vecs[i].ct, vecs[i].cval, vecs[i].cr, 1'b0);
            tick();
            expect_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_dtag,
                         vecs[i].e_cvalid, vecs[i].e_ctag);
            if (vecs[i].e_cvalid) begin
                check($sformatf("vec%0d.commit_dest", i), 64'(commit_dest), 64'(vecs[i].e_cdest));
                check($sformatf("vec%0d.commit_value", i), 64'(commit_value), 64'(vecs[i].e_cvalue));
            end
        end

        // Full: commit while full refuses dispatch; slot reusable next cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'(i + 10), 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        expect_state("fill", 8, 0, 1'b0, 0);
        drive(1'b1, 5'd30, 1'b1, 3'd0, 32'h100, 1'b0, 1'b0);
        tick();
        expect_state("full_cdb", 8, 0, 1'b1, 0);
        check("full_cdb.commit_dest", 64'(commit_dest), 64'd10);
        check("full_cdb.commit_value", 64'(commit_value), 64'h100);
        drive(1'b1, 5'd9, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        expect_state("full_commit", 7, 0, 1'b0, 1);
        drive(1'b1, 5'd9, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        expect_state("wrap_accept", 8, 1, 1'b0, 1);

        // Simultaneous dispatch and commit at count 4.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i + 20), 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 3'd0, 32'hC0FFEE, 1'b0, 1'b0);
        tick();
        expect_state("pre_simul", 4, 4, 1'b1, 0);
        drive(1'b1, 5'd24, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        expect_state("simul", 4, 5, 1'b0, 1);

        // Flush with concurrent dispatch, CDB and commit.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 3'd0, 32'h1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 3'd1, 32'h2, 1'b1, 1'b1);
        tick();
        expect_state("flush", 0, 0, 1'b0, 0);
        drive(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        expect_state("post_flush", 1, 1, 1'b0, 0);
        drive(1'b1, 5'd8, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 3'd6, 32'hDEAD, 1'b0, 1'b0);
        tick();
        expect_state("cdb_invalid", 2, 2, 1'b0, 0);
        drive(1'b0, '0, 1'b1, 3'd0, 32'hBEEF, 1'b0, 1'b0);
        tick();
        expect_state("cdb_after_flush", 2, 2, 1'b1, 0);
        check("cdb_after_flush.commit_dest", 64'(commit_dest), 64'd7);
        check("cdb_after_flush.commit_value", 64'(commit_value), 64'hBEEF);

        // Reset mid-operation beats every other input.
        drive(1'b1, 5'd3, 1'b1, 3'd1, 32'h5, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_state("mid_reset", 0, 0, 1'b0, 0);

        // CDB aimed at the slot being allocated is ignored.
        drive(1'b1, 5'd1, 1'b1, 3'd0, 32'hDEAD, 1'b0, 1'b0);
        tick();
        expect_state("cdb_on_alloc", 1, 1, 1'b0, 0);

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        m_head = 0;
        m_tail = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dispatch_valid = ($urandom_range(9) < 6);
            dispatch_dest  = REG_ADDR_WIDTH'($urandom);
            cdb_valid      = ($urandom_range(1) == 1);
            if (mq.size() > 0 && $urandom_range(3) != 0) begin
                cdb_tag = TAG_WIDTH'(mq[$urandom_range(mq.size() - 1)].tag);
            end else begin
                cdb_tag = TAG_WIDTH'($urandom);
            end
            cdb_value    = $urandom;
            commit_ready = ($urandom_range(1) == 1);
            flush        = ($urandom_range(49) == 0);
            rst_n        = ($urandom_range(199) != 0);
            model_step();
            tick();
            compare_model(cyc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
In-order reorder-buffer controller for the OoO core. It allocates ROB tags to dispatching instructions and records CDB completions against those tags. It retires completed entries strictly in program order to architectural-register commit, and clears all state on a branch-mispredict flush. It owns the circular entry storage plus head/tail/count bookkeeping that the plain ROB FIFO cannot provide (random-access completion, tag return, flush).

Parameters:
DEPTH, 8, number of ROB entries; power of two, >= 2
DATA_WIDTH, 32, result value width
REG_ADDR_WIDTH, 5, architectural destination register index width
TAG_WIDTH, $clog2(DEPTH), ROB tag width (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
dispatch_valid  in  1  dispatch stage presents an instruction
dispatch_dest  in  REG_ADDR_WIDTH  destination arch register of dispatching instruction
dispatch_ready  out  1  = !full; dispatch accepted when dispatch_valid && dispatch_ready
dispatch_tag  out  TAG_WIDTH  tag assigned to the accepted instruction (= tail pointer)
cdb_valid  in  1  CDB broadcast this cycle
cdb_tag  in  TAG_WIDTH  ROB tag of completing instruction
cdb_value  in  DATA_WIDTH  result value
commit_valid  out  1  head entry valid and complete
commit_dest  out  REG_ADDR_WIDTH  head entry destination register
commit_value  out  DATA_WIDTH  head entry result
commit_tag  out  TAG_WIDTH  head pointer
commit_ready  in  1  register file accepts commit; retire on commit_valid && commit_ready
flush  in  1  mispredict: discard all entries
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  TAG_WIDTH+1  occupied entries

Behaviour:
- Entry fields: valid, complete, dest, value. head, tail TAG_WIDTH wide; count TAG_WIDTH+1 wide.
- Reset (rst_n=0 at clk edge): head=tail=0, count=0, all valid/complete cleared. Outputs after reset: full=0, empty=1, count=0, dispatch_ready=1, dispatch_tag=0, commit_valid=0, commit_tag=0. commit_dest/commit_value are don't-care while commit_valid=0. Reset has priority over flush and all other inputs.
- full, empty, count, dispatch_ready, dispatch_tag and commit_* are combinational from registered state only. No combinational path from any input to any output.
- Dispatch accept (dispatch_valid && !full): entry[tail] <= {valid=1, complete=0, dest=dispatch_dest}; tail <= tail+1, wrapping modulo DEPTH.
- Completion (cdb_valid && entry[cdb_tag].valid): complete <= 1, value <= cdb_value. A CDB write to an invalid entry is ignored. Completion is visible on commit_valid the following cycle (1-cycle latency).
- Commit (commit_valid && commit_ready): entry[head].valid <= 0, complete <= 0; head <= head+1 with wrap. At most one commit per cycle.
- Count update: count <= count + accept - retire. Simultaneous accept and retire leaves count unchanged.
- When full and a commit occurs in the same cycle, dispatch is still refused, because full is evaluated on current state. The slot is usable next cycle.
- A CDB write targeting the entry being committed in the same cycle is impossible by construction, since the head is already complete. If it occurs anyway, commit wins and the entry ends invalid.
- A CDB write targeting the tail slot being allocated in the same cycle is ignored, because that entry is invalid in the current state. Allocation wins and the entry is written with complete=0.
- Flush: at the next edge head=tail=0, count=0, all valid/complete cleared. Flush overrides same-cycle dispatch, CDB and commit; none of them takes effect.

Decomposition:
- Package rob_pkg holds rob_entry_t (packed struct: valid, complete, dest, value) and the localparams for DEPTH, DATA_WIDTH, REG_ADDR_WIDTH and TAG_WIDTH.
- One sub-module, rob_entry_array, holds the DEPTH x rob_entry_t storage. It has one allocate write port, one CDB update port, one retire clear port, a synchronous clear for flush/reset, and an asynchronous read of the head entry.
- Pointer/count logic stays in rob_ctrl.

Test Plan:
- Reset then dispatch dest=3,4,5 on consecutive cycles -> dispatch_tag 0,1,2; count=3; empty=0; commit_valid=0.
- CDB tag=1 value=0xAA, then tag=0 value=0x55; commit_ready=1 -> commits dest=3/0x55 then dest=4/0xAA in order; tag 2 not committed until its CDB write arrives.
- Fill 8 entries -> full=1, dispatch_ready=0; complete tag 0 and commit while dispatch_valid=1 -> no accept that cycle; next cycle accept with dispatch_tag=0 (wrap); count=8.
- Simultaneous dispatch and commit with count=4 -> count stays 4, head and tail both advance.
- flush=1 with 5 entries, concurrent dispatch and CDB -> next cycle count=0, empty=1, commit_valid=0; next dispatch gets tag 0.
- CDB to an invalid tag (e.g. 6 when count=2) -> no state change; rst_n=0 mid-operation -> all outputs at reset values next cycle.
